// File: rtl/riscv_rf_wrarb.sv
// Round-robin arbiter sharing the single riscv_rf write port between NREQ
// writeback sources; the winning write is registered before it reaches the RF.
module riscv_rf_wrarb #(
  parameter  int WIDTH = 64,
  parameter  int ADDR  = 5,
  parameter  int NREQ  = 3,
  localparam int IDW   = $clog2(NREQ)
) (
  input  logic                  i_riscv_wrarb_clk,
  input  logic                  i_riscv_wrarb_rst,
  input  logic                  i_riscv_wrarb_stall,
  input  logic [NREQ-1:0]       i_riscv_wrarb_valid,
  input  logic [NREQ*ADDR-1:0]  i_riscv_wrarb_rdaddr,
  input  logic [NREQ*WIDTH-1:0] i_riscv_wrarb_rddata,
  output logic [NREQ-1:0]       o_riscv_wrarb_ready,
  output logic                  o_riscv_wrarb_regwrite,
  output logic [ADDR-1:0]       o_riscv_wrarb_rdaddr,
  output logic [WIDTH-1:0]      o_riscv_wrarb_rddata,
  output logic [IDW-1:0]        o_riscv_wrarb_gntid
);

  logic [IDW-1:0]   ptr_r;
  logic             regwrite_r;
  logic [ADDR-1:0]  rdaddr_r;
  logic [WIDTH-1:0] rddata_r;
  logic [IDW-1:0]   gntid_r;

  logic [NREQ-1:0]  cand_s;
  logic             win_found_s;
  logic [IDW-1:0]   win_idx_s;
  logic [NREQ-1:0]  ready_s;
  logic             transfer_s;
  logic [ADDR-1:0]  rdaddr_win_s;
  logic [WIDTH-1:0] rddata_win_s;

  assign cand_s = i_riscv_wrarb_valid & {NREQ{~i_riscv_wrarb_stall}};

  // Round-robin search starting one past the last winner.
  always_comb begin
    int idx;
    win_found_s = 1'b0;
    win_idx_s   = '0;
    idx         = 0;
    for (int off = 1; off <= NREQ; off++) begin
      idx = (int'(ptr_r) + off) % NREQ;
      if (!win_found_s && cand_s[idx]) begin
        win_found_s = 1'b1;
        win_idx_s   = IDW'(idx);
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  // One-hot grant, forced low while reset is held.
  always_comb begin
    ready_s = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (win_found_s && i_riscv_wrarb_rst && (win_idx_s == IDW'(k))) begin
        ready_s[k] = 1'b1;
      end else begin
        ready_s[k] = 1'b0;
      end
    end
  end

  assign transfer_s   = win_found_s & i_riscv_wrarb_rst;
  assign rdaddr_win_s = i_riscv_wrarb_rdaddr[win_idx_s*ADDR +: ADDR];
  assign rddata_win_s = i_riscv_wrarb_rddata[win_idx_s*WIDTH +: WIDTH];

  // Priority pointer and registered write toward the RF; x0 writes are consumed silently.
  always_ff @(posedge i_riscv_wrarb_clk or negedge i_riscv_wrarb_rst) begin
    if (!i_riscv_wrarb_rst) begin
      ptr_r      <= IDW'(NREQ - 1);
      regwrite_r <= 1'b0;
      rdaddr_r   <= '0;
      rddata_r   <= '0;
      gntid_r    <= '0;
    end else if (transfer_s) begin
      ptr_r      <= win_idx_s;
      regwrite_r <= (rdaddr_win_s != {ADDR{1'b0}});
      rdaddr_r   <= rdaddr_win_s;
      rddata_r   <= rddata_win_s;
      gntid_r    <= win_idx_s;
    end else begin
      regwrite_r <= 1'b0;
    end
  end

  assign o_riscv_wrarb_ready    = ready_s;
  assign o_riscv_wrarb_regwrite = regwrite_r;
  assign o_riscv_wrarb_rdaddr   = rdaddr_r;
  assign o_riscv_wrarb_rddata   = rddata_r;
  assign o_riscv_wrarb_gntid    = gntid_r;

endmodule

// File: tb/tb_riscv_rf_wrarb.sv
// Directed bench for riscv_rf_wrarb: expected output writes are queued when a
// step is driven and compared after the following rising edge.
module tb_riscv_rf_wrarb;

  typedef struct packed {
    logic        rw;
    logic [4:0]  a;
    logic [63:0] d;
    logic [1:0]  g;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         stall;
  logic [2:0]   valid;
  logic [4:0]   addr_in [3];
  logic [63:0]  data_in [3];
  logic [14:0]  rdaddr_bus;
  logic [191:0] rddata_bus;
  logic [2:0]   ready;
  logic         regwrite;
  logic [4:0]   rdaddr;
  logic [63:0]  rddata;
  logic [1:0]   gntid;

  exp_t sb_q[$];
  exp_t last_e;
  int   checks;
  int   errors;

  assign rdaddr_bus = {addr_in[2], addr_in[1], addr_in[0]};
  assign rddata_bus = {data_in[2], data_in[1], data_in[0]};

  riscv_rf_wrarb #(.WIDTH(64), .ADDR(5), .NREQ(3)) dut (
    .i_riscv_wrarb_clk      (clk),
    .i_riscv_wrarb_rst      (rst_n),
    .i_riscv_wrarb_stall    (stall),
    .i_riscv_wrarb_valid    (valid),
    .i_riscv_wrarb_rdaddr   (rdaddr_bus),
    .i_riscv_wrarb_rddata   (rddata_bus),
    .o_riscv_wrarb_ready    (ready),
    .o_riscv_wrarb_regwrite (regwrite),
    .o_riscv_wrarb_rdaddr   (rdaddr),
    .o_riscv_wrarb_rddata   (rddata),
    .o_riscv_wrarb_gntid    (gntid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive valid, check same-cycle grant, queue the expected write, then compare after the edge.
  task automatic step(input logic [2:0] v, input logic [2:0] er);
    exp_t e;
    int   k;
    valid = v;
    #2;
    chk("ready", {61'd0, ready}, {61'd0, er});
    e = last_e;
    e.rw = 1'b0;
    if (er != 3'b000) begin
      k = 0;
      for (int i = 0; i < 3; i++) if (er[i]) k = i;
      e.rw = (addr_in[k] != 5'd0);
      e.a  = addr_in[k];
      e.d  = data_in[k];
      e.g  = 2'(k);
    end
    last_e = e;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    chk("regwrite", {63'd0, regwrite}, {63'd0, e.rw});
    chk("rdaddr",   {59'd0, rdaddr},   {59'd0, e.a});
    chk("rddata",   rddata,            e.d);
    chk("gntid",    {62'd0, gntid},    {62'd0, e.g});
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    last_e  = '0;
    rst_n   = 1'b0;
    stall   = 1'b0;
    valid   = 3'b111;
    addr_in[0] = 5'd5;  data_in[0] = 64'd7;
    addr_in[1] = 5'd2;  data_in[1] = 64'h22;
    addr_in[2] = 5'd3;  data_in[2] = 64'h33;

    // 1. reset held with all requests valid
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready",    {61'd0, ready},    64'd0);
    chk("rst_regwrite", {63'd0, regwrite}, 64'd0);
    chk("rst_rdaddr",   {59'd0, rdaddr},   64'd0);
    chk("rst_rddata",   rddata,            64'd0);
    chk("rst_gntid",    {62'd0, gntid},    64'd0);
    rst_n = 1'b1;
    step(3'b111, 3'b001);

    // 2. single write x5 <= 7
    step(3'b001, 3'b001);
    step(3'b000, 3'b000);

    // 3. round-robin with all sources valid (ptr at req0)
    addr_in[0] = 5'd1; data_in[0] = 64'h11;
    step(3'b111, 3'b010);
    step(3'b111, 3'b100);
    step(3'b111, 3'b001);
    step(3'b111, 3'b010);
    step(3'b111, 3'b100);
    step(3'b111, 3'b001);

    // 4. x0 write is granted but never asserts regwrite
    addr_in[2] = 5'd0; data_in[2] = 64'hAA;
    step(3'b100, 3'b100);
    addr_in[2] = 5'd3; data_in[2] = 64'h33;

    // 5. stall freezes grants and pointer
    step(3'b111, 3'b001);
    stall = 1'b1;
    step(3'b111, 3'b000);
    step(3'b111, 3'b000);
    step(3'b111, 3'b000);
    stall = 1'b0;
    step(3'b111, 3'b010);

    // 6. asynchronous reset while a write is in flight
    step(3'b111, 3'b100);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_regwrite", {63'd0, regwrite}, 64'd0);
    chk("midrst_ready",    {61'd0, ready},    64'd0);
    chk("midrst_rdaddr",   {59'd0, rdaddr},   64'd0);
    chk("midrst_rddata",   rddata,            64'd0);
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    last_e = '0;
    step(3'b111, 3'b001);
    step(3'b000, 3'b000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
